// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// alu_seq_if : operand/result handshake bundle for the sequential ALU
// Rev 1.0
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       func;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, A, B, func, out_ready,
    input  in_ready, out_valid, result, zero, negative, carry, overflow, illegal
  );

  modport slave (
    input  in_valid, A, B, func, out_ready,
    output in_ready, out_valid, result, zero, negative, carry, overflow, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : handshaked multi-cycle ALU (bit-serial shifts, shift-add multiply)
// Rev 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLA  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_func;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_ovf;
  logic             r_ill;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_shift;
  logic             w_multi;
  logic             w_last;
  logic             w_fin;
  logic             w_carry;
  logic             w_ovf;
  logic             w_ill;
  logic [SHW-1:0]   w_k;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_mac;
  logic [WIDTH-1:0] w_res;

  assign w_in_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_k        = bus.B[SHW-1:0];
  assign w_is_shift = (bus.func == OP_SLA) | (bus.func == OP_SRA) | (bus.func == OP_SRL);
  assign w_multi    = (bus.func == OP_MUL) | (w_is_shift & (w_k != '0));
  assign w_last     = (r_cnt == CW'(1));
  // Extra top bit gives carry-out for ADD and borrow for SUB.
  assign w_sum      = {1'b0, bus.A} + {1'b0, bus.B};
  assign w_diff     = {1'b0, bus.A} - {1'b0, bus.B};
  assign w_mac      = r_acc + (r_opb[0] ? r_opa : '0);

  always_comb begin
    case (r_func)
      OP_SLA:  w_step = r_acc << 1;
      OP_SRA:  w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
      default: w_step = r_acc >> 1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.func == OP_MUL) begin
            w_next = S_MUL;
          end else if (w_multi) begin
            w_next = S_SHIFT;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_SHIFT, S_MUL: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // w_fin marks the edge at which a final result and its flags are captured.
  always_comb begin
    w_fin   = 1'b0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_ill   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_multi) begin
          w_fin = 1'b1;
          case (bus.func)
            OP_ADD: begin
              w_res   = w_sum[WIDTH-1:0];
              w_carry = w_sum[WIDTH];
              w_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &
                        (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
              w_res   = w_diff[WIDTH-1:0];
              w_carry = w_diff[WIDTH];
              w_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &
                        (w_diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND:  w_res = bus.A & bus.B;
            OP_OR:   w_res = bus.A | bus.B;
            OP_XOR:  w_res = bus.A ^ bus.B;
            OP_NOT:  w_res = ~bus.A;
            OP_SLA, OP_SRA, OP_SRL: w_res = bus.A;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            default: w_ill = 1'b1;
          endcase
        end
      end
      S_SHIFT: begin
        w_fin = w_last;
        w_res = w_step;
      end
      S_MUL: begin
        w_fin = w_last;
        w_res = w_mac;
      end
      default: w_fin = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_cnt       <= '0;
      r_func      <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_neg       <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_func <= bus.func;
            if (bus.func == OP_MUL) begin
              r_acc <= '0;
              r_opa <= bus.A;
              r_opb <= bus.B;
              r_cnt <= CW'(WIDTH);
            end else begin
              r_acc <= bus.A;
              r_cnt <= {1'b0, w_k};
            end
          end
        end
        S_SHIFT: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CW'(1);
        end
        S_MUL: begin
          r_acc <= w_mac;
          r_opa <= r_opa << 1;
          r_opb <= r_opb >> 1;
          r_cnt <= r_cnt - CW'(1);
        end
        default: r_cnt <= r_cnt;
      endcase

      if (w_fin) begin
        r_result    <= w_res;
        r_zero      <= (w_res == '0) & ~w_ill;
        r_neg       <= w_res[WIDTH-1];
        r_carry     <= w_carry;
        r_ovf       <= w_ovf;
        r_ill       <= w_ill;
        r_out_valid <= 1'b1;
      end else if ((r_state == S_DONE) && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_neg;
  assign bus.carry     = r_carry;
  assign bus.overflow  = r_ovf;
  assign bus.illegal   = r_ill;
endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_seq : directed vector bench for alu_seq (WIDTH=32)
// Rev 1.0
// ============================================================================
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
    logic         il;
    int           lat;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    bus.func     = f;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    bus.func     = 4'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    logic seen;
    logic [W-1:0] held;

    //            func   A             B             result        z    n    c    v    il   L
    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0,1'b1,1'b0,1'b1,1'b0, 1};
    vecs[1]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1,1'b0,1'b1,1'b0,1'b0, 1};
    vecs[2]  = '{4'd1,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0,1'b1,1'b1,1'b0,1'b0, 1};
    vecs[3]  = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0,1'b0,1'b0,1'b1,1'b0, 1};
    vecs[4]  = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0,1'b1,1'b0,1'b0,1'b0, 1};
    vecs[5]  = '{4'd3,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0,1'b0,1'b0,1'b0,1'b0, 1};
    vecs[6]  = '{4'd4,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b1,1'b0,1'b0,1'b0,1'b0, 1};
    vecs[7]  = '{4'd5,  32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 1'b0,1'b1,1'b0,1'b0,1'b0, 1};
    vecs[8]  = '{4'd7,  32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0,1'b1,1'b0,1'b0,1'b0, 32};
    vecs[9]  = '{4'd8,  32'h80000000, 32'h0000001F, 32'h00000001, 1'b0,1'b0,1'b0,1'b0,1'b0, 32};
    vecs[10] = '{4'd6,  32'h00000001, 32'h00000025, 32'h00000020, 1'b0,1'b0,1'b0,1'b0,1'b0, 6};
    vecs[11] = '{4'd6,  32'h12345678, 32'h00000020, 32'h12345678, 1'b0,1'b0,1'b0,1'b0,1'b0, 1};
    vecs[12] = '{4'd7,  32'h7FFFFFF0, 32'h00000004, 32'h07FFFFFF, 1'b0,1'b0,1'b0,1'b0,1'b0, 5};
    vecs[13] = '{4'd9,  32'h00010000, 32'h00010000, 32'h00000000, 1'b1,1'b0,1'b0,1'b0,1'b0, 33};
    vecs[14] = '{4'd9,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0,1'b1,1'b0,1'b0,1'b0, 33};
    vecs[15] = '{4'd9,  32'h00001234, 32'h00000010, 32'h00012340, 1'b0,1'b0,1'b0,1'b0,1'b0, 33};
    vecs[16] = '{4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0,1'b0,1'b0,1'b0,1'b0, 1};
    vecs[17] = '{4'd11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1,1'b0,1'b0,1'b0,1'b0, 1};
    vecs[18] = '{4'd13, 32'h00000005, 32'h00000006, 32'h00000000, 1'b0,1'b0,1'b0,1'b0,1'b1, 1};
    vecs[19] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0,1'b0,1'b0,1'b0,1'b1, 1};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.func      = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  W'(bus.in_ready), '0);
    chk("rst_out_valid", W'(bus.out_valid), '0);
    chk("rst_result",    bus.result, '0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready",  W'(bus.in_ready), W'(1));

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_in_ready", i), W'(bus.in_ready), W'(1));
      run_op(vecs[i].func, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
      chk($sformatf("v%0d_result", i), bus.result, vecs[i].res);
      if (!vecs[i].il)
        chk($sformatf("v%0d_zero", i), W'(bus.zero), W'(vecs[i].z));
      chk($sformatf("v%0d_negative", i), W'(bus.negative), W'(vecs[i].n));
      chk($sformatf("v%0d_carry", i), W'(bus.carry), W'(vecs[i].c));
      chk($sformatf("v%0d_overflow", i), W'(bus.overflow), W'(vecs[i].v));
      chk($sformatf("v%0d_illegal", i), W'(bus.illegal), W'(vecs[i].il));
      handshake();
      chk($sformatf("v%0d_ov_drop", i), W'(bus.out_valid), '0);
    end

    // Reset in the middle of a multiply, with a nonzero stale result present.
    run_op(4'd0, 32'h1, 32'h1, lat);
    chk("pre_rst_result", bus.result, W'(2));
    handshake();
    bus.func = 4'd9; bus.A = 32'd3; bus.B = 32'd5; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", W'(bus.out_valid), '0);
    chk("mid_rst_result",    bus.result, '0);
    chk("mid_rst_flags", W'({bus.zero, bus.negative, bus.carry, bus.overflow, bus.illegal}), '0);
    chk("mid_rst_in_ready",  W'(bus.in_ready), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", W'(bus.in_ready), W'(1));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("no_stale_done", W'(seen), '0);

    // Backpressure: result held, inputs ignored while DONE.
    run_op(4'd1, 32'd10, 32'd3, lat);
    chk("bp_result", bus.result, W'(7));
    held = bus.result;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = c[0];
      bus.A = $urandom;
      bus.B = $urandom;
      bus.func = 4'd0;
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", c),
          W'({bus.out_valid, bus.in_ready, (bus.result == held), bus.zero, bus.negative,
              bus.carry, bus.overflow, bus.illegal}),
          W'(8'b1010_0000));
    end
    bus.in_valid = 1'b0;
    handshake();
    chk("bp_ready_after", W'(bus.in_ready), W'(1));
    bus.func = 4'd0; bus.A = 32'd2; bus.B = 32'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("bp_next_valid",  W'(bus.out_valid), W'(1));
    chk("bp_next_result", bus.result, W'(5));
    handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
